// File: rtl/genesis_pad_filter.sv
`default_nettype none
// ============================================================================
// genesis_pad_filter : debounce, type masking, direction cancel and turbo
//                      for a decoded Genesis/MasterSystem gamepad word.
// Revision 1.0 - initial release
// ============================================================================
module genesis_pad_filter #(
   parameter int STABLE_TICKS = 50000,
   parameter int TURBO_HALF   = 2500000
) (
   input  logic        iCLK,
   input  logic        iN_RESET,
   input  logic [11:0] iGENPAD_DECODED,
   input  logic [1:0]  iGENPAD_TYPE,
   input  logic [2:0]  iTURBO_EN,
   output logic [11:0] oJOY,
   output logic        oJOY_VALID,
   output logic        oJOY_CHANGED
);

   localparam int              C_TW         = (TURBO_HALF > 1) ? $clog2(TURBO_HALF) : 1;
   localparam logic [15:0]     C_STABLE     = 16'(STABLE_TICKS);
   localparam logic [C_TW-1:0] C_TURBO_LAST = C_TW'(TURBO_HALF - 1);

   logic [13:0]     r_cap;
   logic [13:0]     r_cap_prev;
   logic [15:0]     r_stab;
   logic [13:0]     r_acc;
   logic [C_TW-1:0] r_turbo_cnt;
   logic            r_phase;
   logic [2:0]      r_en_held;
   logic [11:0]     r_joy;
   logic [11:0]     r_joy_prev;
   logic            r_valid;
   logic            r_changed;

   logic [15:0]     w_stab_next;
   logic            w_load;
   logic [11:0]     w_type_mask;
   logic [11:0]     w_clean;
   logic [2:0]      w_en_held;
   logic            w_restart;
   logic [C_TW-1:0] w_cnt_eff;
   logic            w_phase_eff;
   logic [11:0]     w_final;

   // Type and buttons travel together so masking never sees a mixed word.
   always_comb begin
      w_stab_next = r_stab;
      if (r_cap != r_cap_prev)
         w_stab_next = '0;
      else if (r_stab != C_STABLE)
         w_stab_next = r_stab + 16'd1;
   end

   assign w_load = (w_stab_next == C_STABLE);

   always_comb begin
      w_type_mask = 12'h000;
      case (r_acc[13:12])
         2'd0:    w_type_mask = 12'h06F;
         2'd1:    w_type_mask = 12'h0FF;
         2'd2:    w_type_mask = 12'hFFF;
         default: w_type_mask = 12'h000;
      endcase
   end

   always_comb begin
      w_clean = r_acc[11:0] & w_type_mask;
      if (w_clean[3] && w_clean[2])
         w_clean[3:2] = 2'b00;
      if (w_clean[1] && w_clean[0])
         w_clean[1:0] = 2'b00;
   end

   // A fresh press with no other turbo button held starts a new high phase
   // in this very cycle, so the first press is never delayed.
   assign w_en_held   = w_clean[6:4] & iTURBO_EN;
   assign w_restart   = (|w_en_held) && (r_en_held == 3'b000);
   assign w_cnt_eff   = w_restart ? '0 : r_turbo_cnt;
   assign w_phase_eff = w_restart ? 1'b1 : r_phase;

   always_comb begin
      w_final      = w_clean;
      w_final[6:4] = (w_clean[6:4] & ~iTURBO_EN) | (w_en_held & {3{w_phase_eff}});
   end

   always_ff @(posedge iCLK or negedge iN_RESET) begin
      if (!iN_RESET) begin
         r_cap       <= '0;
         r_cap_prev  <= '0;
         r_stab      <= '0;
         r_acc       <= '0;
         r_turbo_cnt <= '0;
         r_phase     <= 1'b1;
         r_en_held   <= '0;
         r_joy       <= '0;
         r_joy_prev  <= '0;
         r_valid     <= 1'b0;
         r_changed   <= 1'b0;
      end else begin
         r_cap      <= {iGENPAD_TYPE, iGENPAD_DECODED};
         r_cap_prev <= r_cap;
         r_stab     <= w_stab_next;
         if (w_load)
            r_acc <= r_cap;

         if (w_cnt_eff == C_TURBO_LAST) begin
            r_turbo_cnt <= '0;
            r_phase     <= ~w_phase_eff;
         end else begin
            r_turbo_cnt <= w_cnt_eff + C_TW'(1);
            r_phase     <= w_phase_eff;
         end
         r_en_held <= w_en_held;

         r_joy      <= w_final;
         r_valid    <= (r_acc[13:12] == 2'd1) || (r_acc[13:12] == 2'd2);
         r_joy_prev <= r_joy;
         r_changed  <= (r_joy != r_joy_prev);
      end
   end

   assign oJOY         = r_joy;
   assign oJOY_VALID   = r_valid;
   assign oJOY_CHANGED = r_changed;

endmodule
`default_nettype wire

// File: tb/tb_genesis_pad_filter.sv
`default_nettype none
// ============================================================================
// tb_genesis_pad_filter : directed self-checking bench, STABLE_TICKS=4, TURBO_HALF=8.
// Revision 1.0 - initial release
// ============================================================================
module tb_genesis_pad_filter;

   logic        clk;
   logic        rst_n;
   logic [11:0] dec;
   logic [1:0]  typ;
   logic [2:0]  ten;
   logic [11:0] joy;
   logic        valid;
   logic        changed;

   int checks = 0;
   int errors = 0;

   genesis_pad_filter #(.STABLE_TICKS(4), .TURBO_HALF(8)) dut (
      .iCLK            (clk),
      .iN_RESET        (rst_n),
      .iGENPAD_DECODED (dec),
      .iGENPAD_TYPE    (typ),
      .iTURBO_EN       (ten),
      .oJOY            (joy),
      .oJOY_VALID      (valid),
      .oJOY_CHANGED    (changed)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Leaves the bench at a negedge with reset just released; the next
   // posedge is edge 0 for whatever inputs the caller sets now.
   task automatic apply_reset();
      rst_n = 1'b0;
      dec   = 12'h000;
      typ   = 2'd0;
      ten   = 3'b000;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Observes the state after edge 6 of a newly applied word.
   task automatic drive_and_wait(input logic [1:0] t, input logic [11:0] d);
      typ = t;
      dec = d;
      repeat (7) @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      @(negedge clk);
      checks++;
      if (joy !== 12'h000) begin errors++; $display("FAIL reset_joy got %h want %h", joy, 12'h000); end
      checks++;
      if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid); end
      checks++;
      if (changed !== 1'b0) begin errors++; $display("FAIL reset_changed got %b want 0", changed); end
      rst_n = 1'b1;
      for (int e = 0; e < 10; e++) begin
         @(negedge clk);
         checks++;
         if (joy !== 12'h000 || changed !== 1'b0) begin
            errors++;
            $display("FAIL zero_after_reset e%0d got joy=%h chg=%b want 000/0", e, joy, changed);
         end
      end
   endtask

   task automatic test_accept();
      logic [11:0] exp;
      apply_reset();
      typ = 2'd1;
      dec = 12'h010;
      for (int e = 0; e < 10; e++) begin
         @(negedge clk);
         exp = (e >= 6) ? 12'h010 : 12'h000;
         checks++;
         if (joy !== exp) begin errors++; $display("FAIL accept_joy e%0d got %h want %h", e, joy, exp); end
         checks++;
         if (valid !== (e >= 6)) begin errors++; $display("FAIL accept_valid e%0d got %b want %b", e, valid, e >= 6); end
         checks++;
         if (changed !== (e == 7)) begin errors++; $display("FAIL accept_changed e%0d got %b want %b", e, changed, e == 7); end
      end
   endtask

   task automatic test_glitch();
      apply_reset();
      typ = 2'd2;
      for (int i = 0; i < 40; i++) begin
         dec = (((i / 3) % 2) == 0) ? 12'h001 : 12'h000;
         @(negedge clk);
         checks++;
         if (joy !== 12'h000 || changed !== 1'b0) begin
            errors++;
            $display("FAIL glitch c%0d got joy=%h chg=%b want 000/0", i, joy, changed);
         end
      end
   endtask

   task automatic test_mask();
      apply_reset();
      drive_and_wait(2'd0, 12'hFFF);
      checks++;
      if (joy !== 12'h060 || valid !== 1'b0) begin errors++; $display("FAIL mask_t0 got %h/%b want 060/0", joy, valid); end
      drive_and_wait(2'd3, 12'hFFF);
      checks++;
      if (joy !== 12'h000 || valid !== 1'b0) begin errors++; $display("FAIL mask_t3 got %h/%b want 000/0", joy, valid); end
      drive_and_wait(2'd1, 12'hFFF);
      checks++;
      if (joy !== 12'h0F0 || valid !== 1'b1) begin errors++; $display("FAIL mask_t1 got %h/%b want 0F0/1", joy, valid); end
      drive_and_wait(2'd2, 12'hFFF);
      checks++;
      if (joy !== 12'hFF0 || valid !== 1'b1) begin errors++; $display("FAIL mask_t2 got %h/%b want FF0/1", joy, valid); end
   endtask

   task automatic test_cancel();
      drive_and_wait(2'd2, 12'h00C);
      checks++;
      if (joy !== 12'h000) begin errors++; $display("FAIL cancel_ud got %h want 000", joy); end
      drive_and_wait(2'd2, 12'h008);
      checks++;
      if (joy !== 12'h008) begin errors++; $display("FAIL cancel_u got %h want 008", joy); end
      drive_and_wait(2'd2, 12'h003);
      checks++;
      if (joy !== 12'h000) begin errors++; $display("FAIL cancel_lr got %h want 000", joy); end
      drive_and_wait(2'd2, 12'h006);
      checks++;
      if (joy !== 12'h006) begin errors++; $display("FAIL cancel_dl got %h want 006", joy); end
   endtask

   task automatic test_turbo();
      logic [11:0] exp;
      apply_reset();
      ten = 3'b001;
      typ = 2'd1;
      dec = 12'h030;
      for (int e = 0; e < 38; e++) begin
         @(negedge clk);
         if (e < 6)
            exp = 12'h000;
         else
            exp = 12'h020 | (((((e - 6) / 8) % 2) == 0) ? 12'h010 : 12'h000);
         checks++;
         if (joy !== exp) begin errors++; $display("FAIL turbo e%0d got %h want %h", e, joy, exp); end
      end
      ten = 3'b000;
   endtask

   task automatic test_reset_mid();
      logic [11:0] exp;
      apply_reset();
      drive_and_wait(2'd2, 12'h040);
      checks++;
      if (joy !== 12'h040 || valid !== 1'b1) begin errors++; $display("FAIL pre_reset got %h/%b want 040/1", joy, valid); end
      dec = 12'h800;
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (joy !== 12'h000 || valid !== 1'b0 || changed !== 1'b0) begin
         errors++;
         $display("FAIL async_reset got %h/%b/%b want 000/0/0", joy, valid, changed);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int e = 0; e < 9; e++) begin
         @(negedge clk);
         exp = (e >= 6) ? 12'h800 : 12'h000;
         checks++;
         if (joy !== exp) begin errors++; $display("FAIL reacquire e%0d got %h want %h", e, joy, exp); end
         checks++;
         if (changed !== (e == 7)) begin errors++; $display("FAIL reacquire_chg e%0d got %b want %b", e, changed, e == 7); end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      dec   = 12'h000;
      typ   = 2'd0;
      ten   = 3'b000;
      test_reset();
      test_accept();
      test_glitch();
      test_mask();
      test_cancel();
      test_turbo();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
